// File: rtl/decode_operand_stage_if.sv
// Decode-slot bus: upstream instruction, regfile read port, forwarding window and execute handoff.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready carry the valid-ready handshakes on either side of the slot.
//
// Ports (slave = the decode slot, master = its environment):
//   flush, in_*            : upstream instruction and synchronous kill
//   rf_idx*/rf_val*        : combinational regfile read
//   fwd_*                  : NFWD in-flight producers, slot 0 youngest
//   out_*, hazard          : resolved instruction towards execute
interface decode_operand_stage_if #(
  parameter int XLEN = 32,
  parameter int RW   = 5,
  parameter int NFWD = 3
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [XLEN-1:0]      in_pc;
  logic [RW-1:0]        in_rs;
  logic [RW-1:0]        in_rt;
  logic [RW-1:0]        in_dst;
  logic [1:0]           in_use;
  logic [2:0]           in_cmp;
  logic [RW-1:0]        rf_idx1;
  logic [RW-1:0]        rf_idx2;
  logic [XLEN-1:0]      rf_val1;
  logic [XLEN-1:0]      rf_val2;
  logic [NFWD-1:0]      fwd_valid;
  logic [NFWD-1:0]      fwd_ready;
  logic [NFWD*RW-1:0]   fwd_dst;
  logic [NFWD*XLEN-1:0] fwd_val;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_pc;
  logic [RW-1:0]        out_dst;
  logic [XLEN-1:0]      out_val1;
  logic [XLEN-1:0]      out_val2;
  logic                 out_jump;
  logic                 hazard;

  modport master (
    output flush, in_valid, in_pc, in_rs, in_rt, in_dst, in_use, in_cmp,
    output rf_val1, rf_val2, fwd_valid, fwd_ready, fwd_dst, fwd_val, out_ready,
    input  in_ready, rf_idx1, rf_idx2,
    input  out_valid, out_pc, out_dst, out_val1, out_val2, out_jump, hazard
  );

  modport slave (
    input  flush, in_valid, in_pc, in_rs, in_rt, in_dst, in_use, in_cmp,
    input  rf_val1, rf_val2, fwd_valid, fwd_ready, fwd_dst, fwd_val, out_ready,
    output in_ready, rf_idx1, rf_idx2,
    output out_valid, out_pc, out_dst, out_val1, out_val2, out_jump, hazard
  );
endinterface

// File: rtl/decode_operand_stage.sv
// Decode pipeline slot: holds one instruction, resolves rs/rt against NFWD forwarding sources (youngest first) or the regfile.
// Latency: 1 cycle in->out when no hazard; one instruction per cycle back-to-back.
// Backpressure: in_ready drops while an operand is unresolved or out_ready is low; held outputs stay stable.
//
// Ports: clk, resetn (async active-low) plain; everything else on bus (decode_operand_stage_if.slave):
//   flush/in_* from fetch, rf_idx*/rf_val* regfile read, fwd_* producer window,
//   out_*/hazard towards execute.
// Optional feature: define DECODE_BRANCH_EN to hold in_cmp and drive out_jump from a signed compare;
// without it out_jump is tied 0 and in_cmp is not stored.
module decode_operand_stage #(
  parameter int XLEN = 32,
  parameter int RW   = 5,
  parameter int NFWD = 3
) (
  input logic                   clk,
  input logic                   resetn,
  decode_operand_stage_if.slave bus
);

  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_FULL} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [RW-1:0]   r_rs;
  logic [RW-1:0]   r_rt;
  logic [RW-1:0]   r_dst;
  logic [1:0]      r_use;
  logic            r_have1;
  logic            r_have2;
  logic [XLEN-1:0] r_lat1;
  logic [XLEN-1:0] r_lat2;

  logic [XLEN:0]   w_r1;
  logic [XLEN:0]   w_r2;
  logic            w_res1;
  logic            w_res2;
  logic [XLEN-1:0] w_val1;
  logic [XLEN-1:0] w_val2;
  logic            w_held;
  logic            w_out_valid;
  logic            w_depart;
  logic            w_in_ready;
  logic            w_load;

  // Returns {resolved, value} for one source operand. The first matching
  // producer in the scan decides: if it is not ready yet, older producers
  // with the same destination hold stale data and must not be used.
  function automatic logic [XLEN:0] f_resolve(
    input logic                 use_b,
    input logic [RW-1:0]        idx,
    input logic                 have,
    input logic [XLEN-1:0]      lat,
    input logic [XLEN-1:0]      rf,
    input logic [NFWD-1:0]      fv,
    input logic [NFWD-1:0]      fr,
    input logic [NFWD*RW-1:0]   fd,
    input logic [NFWD*XLEN-1:0] fval
  );
    logic            res;
    logic            hit;
    logic [XLEN-1:0] val;
    res = 1'b1;
    hit = 1'b0;
    val = rf;
    if (!use_b || idx == '0) begin
      val = '0;
    end else if (have) begin
      val = lat;
    end else begin
      for (int i = 0; i < NFWD; i++) begin
        if (!hit && fv[i] && fd[i*RW +: RW] == idx) begin
          hit = 1'b1;
          res = fr[i];
          val = fr[i] ? fval[i*XLEN +: XLEN] : rf;
        end
      end
    end
    return {res, val};
  endfunction

  assign w_r1 = f_resolve(r_use[0], r_rs, r_have1, r_lat1, bus.rf_val1,
                          bus.fwd_valid, bus.fwd_ready, bus.fwd_dst, bus.fwd_val);
  assign w_r2 = f_resolve(r_use[1], r_rt, r_have2, r_lat2, bus.rf_val2,
                          bus.fwd_valid, bus.fwd_ready, bus.fwd_dst, bus.fwd_val);

  assign w_res1 = w_r1[XLEN];
  assign w_val1 = w_r1[XLEN-1:0];
  assign w_res2 = w_r2[XLEN];
  assign w_val2 = w_r2[XLEN-1:0];

  // Handshakes use live resolution; WAIT/FULL is bookkeeping of the last cycle's view.
  assign w_held      = (r_state != S_EMPTY);
  assign w_out_valid = w_held && w_res1 && w_res2;
  assign w_depart    = w_out_valid && bus.out_ready;
  assign w_in_ready  = !bus.flush && (!w_held || w_depart);
  assign w_load      = bus.in_valid && w_in_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.rf_idx1   = r_rs;
  assign bus.rf_idx2   = r_rt;
  assign bus.out_valid = w_out_valid;
  assign bus.hazard    = w_held && !(w_res1 && w_res2);
  assign bus.out_pc    = r_pc;
  assign bus.out_dst   = r_dst;
  assign bus.out_val1  = w_val1;
  assign bus.out_val2  = w_val2;

`ifdef DECODE_BRANCH_EN
  logic [2:0] r_cmp;
  logic       w_cmp_hit;

  always_comb begin
    w_cmp_hit = 1'b0;
    case (r_cmp)
      3'd1:    w_cmp_hit = (w_val1 == w_val2);
      3'd2:    w_cmp_hit = (w_val1 != w_val2);
      3'd3:    w_cmp_hit = !w_val1[XLEN-1];
      3'd4:    w_cmp_hit = w_val1[XLEN-1];
      3'd5:    w_cmp_hit = !w_val1[XLEN-1] && (w_val1 != '0);
      3'd6:    w_cmp_hit = w_val1[XLEN-1] || (w_val1 == '0);
      default: w_cmp_hit = 1'b0;
    endcase
  end

  assign bus.out_jump = w_out_valid && w_cmp_hit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cmp <= '0;
    end else if (w_load) begin
      r_cmp <= bus.in_cmp;
    end
  end
`else
  logic w_unused_cmp;
  assign w_unused_cmp = ^bus.in_cmp;
  assign bus.out_jump = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_EMPTY;
      r_pc    <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_dst   <= '0;
      r_use   <= '0;
      r_have1 <= 1'b0;
      r_have2 <= 1'b0;
      r_lat1  <= '0;
      r_lat2  <= '0;
    end else if (bus.flush) begin
      r_state <= S_EMPTY;
      r_have1 <= 1'b0;
      r_have2 <= 1'b0;
    end else if (w_load) begin
      r_state <= S_WAIT;
      r_pc    <= bus.in_pc;
      r_rs    <= bus.in_rs;
      r_rt    <= bus.in_rt;
      r_dst   <= bus.in_dst;
      r_use   <= bus.in_use;
      r_have1 <= 1'b0;
      r_have2 <= 1'b0;
    end else if (w_depart) begin
      r_state <= S_EMPTY;
    end else if (w_held) begin
      // Capture operands as soon as they resolve so a producer that leaves
      // the forwarding window while the other operand stalls is not lost.
      if (w_res1 && !r_have1) begin
        r_have1 <= 1'b1;
        r_lat1  <= w_val1;
      end
      if (w_res2 && !r_have2) begin
        r_have2 <= 1'b1;
        r_lat2  <= w_val2;
      end
      r_state <= (w_res1 && w_res2) ? S_FULL : S_WAIT;
    end
  end

endmodule

// File: tb/tb_decode_operand_stage.sv
module tb_decode_operand_stage;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int NFWD = 3;
`ifdef DECODE_BRANCH_EN
  localparam logic BR = 1'b1;
`else
  localparam logic BR = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  dst;
    logic [31:0] v1;
    logic [31:0] v2;
    logic        j;
  } sb_t;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [1:0]  ub;
    logic [2:0]  cmp;
    logic [2:0]  fv;
    logic [2:0]  fr;
    logic [14:0] fd;
    logic [95:0] fval;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        ej;
  } vec_t;

  logic        clk;
  logic        resetn;
  logic [31:0] rf [32];
  sb_t         sb[$];
  sb_t         exp_next;
  vec_t        tbl[10];
  int          n_asrt;
  int          n_fail;

  decode_operand_stage_if #(.XLEN(XLEN), .RW(RW), .NFWD(NFWD)) bus ();

  decode_operand_stage #(.XLEN(XLEN), .RW(RW), .NFWD(NFWD)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  assign bus.rf_val1 = rf[bus.rf_idx1];
  assign bus.rf_val2 = rf[bus.rf_idx2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic sb_t mk_exp(logic [31:0] pc, logic [4:0] dst, logic [31:0] v1,
                                 logic [31:0] v2, logic j);
    sb_t e;
    e.pc = pc; e.dst = dst; e.v1 = v1; e.v2 = v2; e.j = j;
    return e;
  endfunction

  function automatic vec_t mk_vec(logic [31:0] pc, logic [4:0] rs, logic [4:0] rt, logic [4:0] dst,
                                  logic [1:0] ub, logic [2:0] cmp, logic [2:0] fv, logic [2:0] fr,
                                  logic [4:0] d0, logic [4:0] d1, logic [4:0] d2,
                                  logic [31:0] v0, logic [31:0] v1, logic [31:0] v2,
                                  logic [31:0] e1, logic [31:0] e2, logic ej);
    vec_t v;
    v.pc = pc; v.rs = rs; v.rt = rt; v.dst = dst; v.ub = ub; v.cmp = cmp;
    v.fv = fv; v.fr = fr; v.fd = {d2, d1, d0}; v.fval = {v2, v1, v0};
    v.e1 = e1; v.e2 = e2; v.ej = ej;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.fwd_valid = '0;
    bus.fwd_ready = '0;
    bus.fwd_dst   = '0;
    bus.fwd_val   = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] dst, input logic [1:0] ub, input logic [2:0] cmp,
                       input sb_t e);
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_rs    = rs;
    bus.in_rt    = rt;
    bus.in_dst   = dst;
    bus.in_use   = ub;
    bus.in_cmp   = cmp;
    exp_next     = e;
  endtask

  // Scoreboard hook, called once per cycle mid-cycle: push on accept, pop/compare on depart.
  task automatic sample();
    sb_t e;
    #2;
    if (bus.in_valid && bus.in_ready) sb.push_back(exp_next);
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("out_pc", bus.out_pc, e.pc);
        chk("out_dst", bus.out_dst, e.dst);
        chk("out_val1", bus.out_val1, e.v1);
        chk("out_val2", bus.out_val2, e.v2);
        chk("out_jump", bus.out_jump, e.j);
      end
    end
  endtask

  initial begin
    n_asrt = 0;
    n_fail = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    rf[3]  = 32'h11;
    rf[12] = 32'h20;
    rf[13] = 32'h20;
    rf[14] = 32'h8000_0000;

    tbl[0] = mk_vec(32'h1000, 3, 4, 1, 2'b11, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 32'h11, 32'h104, 0);
    tbl[1] = mk_vec(32'h1004, 5, 0, 2, 2'b01, 0, 3'b101, 3'b101, 5, 0, 5, 32'hA, 0, 32'hC, 32'hA, 0, 0);
    tbl[2] = mk_vec(32'h1008, 6, 6, 3, 2'b11, 0, 3'b010, 3'b010, 0, 6, 0, 0, 32'h66, 0, 32'h66, 32'h66, 0);
    tbl[3] = mk_vec(32'h100C, 3, 4, 4, 2'b00, 0, 3'b001, 3'b001, 3, 0, 0, 32'hDEAD, 0, 0, 0, 0, 0);
    tbl[4] = mk_vec(32'h1010, 8, 9, 5, 2'b11, 0, 3'b101, 3'b101, 9, 0, 8, 32'h90, 0, 32'h88, 32'h88, 32'h90, 0);
    tbl[5] = mk_vec(32'h1014, 10, 11, 6, 2'b11, 0, 3'b000, 3'b111, 10, 11, 0, 1, 2, 3, 32'h10A, 32'h10B, 0);
    tbl[6] = mk_vec(32'h1018, 0, 0, 7, 2'b11, 0, 3'b111, 3'b111, 0, 0, 0, 5, 5, 5, 0, 0, 0);
    tbl[7] = mk_vec(32'h101C, 12, 13, 8, 2'b11, 1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 32'h20, 32'h20, BR);
    tbl[8] = mk_vec(32'h1020, 14, 0, 9, 2'b01, 4, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 32'h8000_0000, 0, BR);
    tbl[9] = mk_vec(32'h1024, 12, 13, 10, 2'b11, 2, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 32'h20, 32'h20, 0);

    // Reset state
    resetn = 1'b0;
    idle();
    drive(0, 0, 0, 0, 0, 0, mk_exp(0, 0, 0, 0, 0));
    bus.in_valid = 1'b0;
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_hazard", bus.hazard, 0);
    chk("rst_out_jump", bus.out_jump, 0);
    chk("rst_out_pc", bus.out_pc, 0);
    chk("rst_out_val1", bus.out_val1, 0);
    chk("rst_out_val2", bus.out_val2, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // Table: load one cycle, apply forwarding the next cycle while held
    for (int k = 0; k < 10; k++) begin
      idle();
      drive(tbl[k].pc, tbl[k].rs, tbl[k].rt, tbl[k].dst, tbl[k].ub, tbl[k].cmp,
            mk_exp(tbl[k].pc, tbl[k].dst, tbl[k].e1, tbl[k].e2, tbl[k].ej));
      sample();
      chk("tbl_in_ready", bus.in_ready, 1);
      tick();
      idle();
      bus.fwd_valid = tbl[k].fv;
      bus.fwd_ready = tbl[k].fr;
      bus.fwd_dst   = tbl[k].fd;
      bus.fwd_val   = tbl[k].fval;
      sample();
      chk("tbl_out_valid", bus.out_valid, 1);
      tick();
    end

    // Back-to-back: 4 loads, 4 consecutive outputs
    for (int k = 0; k < 4; k++) begin
      idle();
      drive(32'h1100 + 4 * k, k + 1, 0, 5'd20 + k, 2'b01, 0,
            mk_exp(32'h1100 + 4 * k, 5'd20 + k, rf[k + 1], 0, 0));
      sample();
      chk("b2b_in_ready", bus.in_ready, 1);
      if (k > 0) chk("b2b_out_valid", bus.out_valid, 1);
      tick();
    end
    idle();
    sample();
    chk("b2b_last_valid", bus.out_valid, 1);
    tick();
    sample();
    chk("b2b_drained", bus.out_valid, 0);
    tick();

    // Load-use: youngest not-ready match blocks an older ready one
    idle();
    drive(32'h2000, 0, 7, 2, 2'b10, 0, mk_exp(32'h2000, 2, 0, 32'h55, 0));
    sample();
    tick();
    for (int c = 0; c < 2; c++) begin
      idle();
      bus.fwd_valid = 3'b101;
      bus.fwd_ready = 3'b100;
      bus.fwd_dst   = {5'd7, 5'd0, 5'd7};
      bus.fwd_val   = {32'hBAD, 32'h0, 32'h0};
      sample();
      chk("lu_hazard", bus.hazard, 1);
      chk("lu_in_ready", bus.in_ready, 0);
      chk("lu_out_valid", bus.out_valid, 0);
      tick();
    end
    bus.fwd_ready = 3'b101;
    bus.fwd_val   = {32'hBAD, 32'h0, 32'h55};
    sample();
    chk("lu_release_hazard", bus.hazard, 0);
    chk("lu_release_valid", bus.out_valid, 1);
    tick();

    // Latch retention: rs resolved from fwd2, which then leaves the window
    idle();
    drive(32'h3000, 8, 9, 3, 2'b11, 0, mk_exp(32'h3000, 3, 32'h99, 32'h77, 0));
    sample();
    tick();
    idle();
    bus.fwd_valid = 3'b101;
    bus.fwd_ready = 3'b100;
    bus.fwd_dst   = {5'd8, 5'd0, 5'd9};
    bus.fwd_val   = {32'h99, 32'h0, 32'h0};
    sample();
    chk("ret_hazard1", bus.hazard, 1);
    tick();
    bus.fwd_valid = 3'b001;
    bus.fwd_ready = 3'b000;
    bus.fwd_dst   = {5'd0, 5'd0, 5'd9};
    bus.fwd_val   = '0;
    sample();
    chk("ret_hazard2", bus.hazard, 1);
    chk("ret_val1_held", bus.out_val1, 32'h99);
    tick();
    bus.fwd_ready = 3'b001;
    bus.fwd_val   = {32'h0, 32'h0, 32'h77};
    sample();
    chk("ret_release", bus.out_valid, 1);
    tick();

    // out_ready low in FULL: outputs stable even when the regfile changes
    idle();
    drive(32'h4000, 3, 0, 4, 2'b01, 0, mk_exp(32'h4000, 4, 32'h11, 0, 0));
    sample();
    tick();
    idle();
    bus.out_ready = 1'b0;
    sample();
    chk("stall_valid", bus.out_valid, 1);
    chk("stall_in_ready", bus.in_ready, 0);
    chk("stall_val1", bus.out_val1, 32'h11);
    tick();
    rf[3] = 32'h3333;
    sample();
    chk("stall_val1_stable", bus.out_val1, 32'h11);
    chk("stall_pc_stable", bus.out_pc, 32'h4000);
    tick();
    bus.out_ready = 1'b1;
    sample();
    tick();
    rf[3] = 32'h11;

    // Flush in WAIT with a new instruction offered
    idle();
    drive(32'h5000, 0, 7, 5, 2'b10, 0, mk_exp(32'h5000, 5, 0, 0, 0));
    sample();
    tick();
    idle();
    bus.fwd_valid = 3'b001;
    bus.fwd_dst   = {5'd0, 5'd0, 5'd7};
    bus.flush     = 1'b1;
    drive(32'h5100, 3, 0, 6, 2'b01, 0, mk_exp(32'h5100, 6, 32'h11, 0, 0));
    sample();
    chk("flush_in_ready", bus.in_ready, 0);
    chk("flush_hazard_before", bus.hazard, 1);
    sb.delete();
    tick();
    idle();
    sample();
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_hazard", bus.hazard, 0);
    chk("flush_in_ready_after", bus.in_ready, 1);
    tick();

    // Asynchronous reset mid-stall
    idle();
    drive(32'h6000, 4, 7, 6, 2'b11, 3, mk_exp(32'h6000, 6, 0, 0, 0));
    sample();
    tick();
    idle();
    bus.fwd_valid = 3'b001;
    bus.fwd_dst   = {5'd0, 5'd0, 5'd7};
    sample();
    chk("ar_hazard_before", bus.hazard, 1);
    #1;
    resetn = 1'b0;
    #1;
    chk("ar_out_valid", bus.out_valid, 0);
    chk("ar_hazard", bus.hazard, 0);
    chk("ar_out_pc", bus.out_pc, 0);
    chk("ar_out_dst", bus.out_dst, 0);
    chk("ar_out_val1", bus.out_val1, 0);
    chk("ar_out_val2", bus.out_val2, 0);
    chk("ar_out_jump", bus.out_jump, 0);
    sb.delete();
    @(negedge clk);
    resetn = 1'b1;
    idle();
    tick();

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
